// File: rtl/murmur_kmer_hasher_seq_pkg.sv
// Purpose:      shared constants, types, state encoding and mixing helpers for the k-mer hasher.
// Latency:      n/a (package; functions are purely combinational).
// Backpressure: n/a.
// Contents: C1/C2 block-mix multipliers, M5/N_ADD body constants, FMIX_C1/FMIX_C2 finaliser
//           multipliers, base_t/h32_t types, hstate_e FSM encoding, rol32/mix_k/fmix32.
`timescale 1ns/1ps

package hasher_pkg;

  typedef logic [1:0]  base_t;
  typedef logic [31:0] h32_t;

  localparam h32_t C1      = 32'hcc9e2d51;
  localparam h32_t C2      = 32'h1b873593;
  localparam h32_t M5      = 32'd5;
  localparam h32_t N_ADD   = 32'he6546b64;
  localparam h32_t FMIX_C1 = 32'h85ebca6b;
  localparam h32_t FMIX_C2 = 32'hc2b2ae35;

  typedef enum logic [2:0] {
    IDLE,
    BLOCK,
    TAIL,
    FINAL,
    DONE
  } hstate_e;

  // Rotate left by n (1..31).
  function automatic h32_t rol32(input h32_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Per-word scramble applied to both full blocks and the tail word.
  function automatic h32_t mix_k(input h32_t w);
    h32_t k;
    k = w * C1;
    k = rol32(k, 15);
    k = k * C2;
    return k;
  endfunction

  // Avalanche finaliser.
  function automatic h32_t fmix32(input h32_t h_in);
    h32_t h;
    h = h_in;
    h = h ^ (h >> 16);
    h = h * FMIX_C1;
    h = h ^ (h >> 13);
    h = h * FMIX_C2;
    h = h ^ (h >> 16);
    return h;
  endfunction

endpackage

// File: rtl/murmur_kmer_hasher_seq_if.sv
// Purpose:      request/response channel of the k-mer hasher (k-mer + tag in, hash + tag out).
// Latency:      n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, in_kmer[2*KMER_SIZE], in_tag[TAG_W];
//        out_valid, out_ready, out_h1[32], out_h2[H2_W], out_tag[TAG_W].
//        master = producer/consumer side, slave = hasher side.
`timescale 1ns/1ps

interface murmur_kmer_hasher_seq_if #(
  parameter int KMER_SIZE = 32,
  parameter int TAG_W     = 8,
  parameter int H2_W      = 8
);

  logic                   in_valid;
  logic                   in_ready;
  logic [2*KMER_SIZE-1:0] in_kmer;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_h1;
  logic [H2_W-1:0]        out_h2;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_kmer, in_tag, out_ready,
    input  in_ready, out_valid, out_h1, out_h2, out_tag
  );

  modport slave (
    input  in_valid, in_kmer, in_tag, out_ready,
    output in_ready, out_valid, out_h1, out_h2, out_tag
  );

endinterface

// File: rtl/murmur_kmer_hasher_seq_round.sv
// Purpose:      one combinational MurmurHash3 round, shared by full-block and tail steps.
// Latency:      0 cycles (combinational).
// Backpressure: none; the caller decides when to register h_out.
// Ports: h_in (running hash), w (32-bit packed word), is_tail (skip rol13/*5+n), h_out.
`timescale 1ns/1ps

module murmur_round
  import hasher_pkg::*;
(
  input  h32_t h_in,
  input  h32_t w,
  input  logic is_tail,
  output h32_t h_out
);

  h32_t hx;

  always_comb begin
    hx = h_in ^ mix_k(w);
    if (is_tail) begin
      h_out = hx;
    end else begin
      h_out = rol32(hx, 13) * M5 + N_ADD;
    end
  end

endmodule

// File: rtl/murmur_kmer_hasher_seq.sv
// Purpose:      sequential MurmurHash3-32 over a 2-bit-per-base k-mer, one 16-base word per cycle.
// Latency:      accept to out_valid = NFULL + (TAILB != 0) + 1 cycles; one k-mer per latency + 2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then back to IDLE.
// Ports: clk, rst (synchronous, active high), bus (murmur_kmer_hasher_seq_if.slave).
// Build option: define HASHER_FMIX_EN to fold in the byte length and run fmix32 in FINAL;
//               without it FINAL passes the body hash straight through (legacy-compatible).
`timescale 1ns/1ps

module murmur_kmer_hasher_seq
  import hasher_pkg::*;
#(
  parameter int   KMER_SIZE      = 32,
  parameter int   NUM_OF_BUCKETS = 256,
  parameter h32_t SEED           = 32'h8f83adef,
  parameter int   TAG_W          = 8
) (
  input logic                     clk,
  input logic                     rst,
  murmur_kmer_hasher_seq_if.slave bus
);

  localparam int NFULL = KMER_SIZE / 16;
  localparam int TAILB = KMER_SIZE % 16;
  localparam int H2_W  = $clog2(NUM_OF_BUCKETS);
  localparam int KW    = 2 * KMER_SIZE;
  // The k-mer is parked left-aligned in a buffer a whole word wider than the
  // full blocks, so the current word is always the top 32 bits, even for K < 16.
  localparam int BUFW  = 32 * (NFULL + 1);
  localparam int PADW  = BUFW - KW;
  // Tail bases arrive left-aligned at the top of the buffer; shift them down.
  localparam int TSH   = (TAILB == 0) ? 0 : 32 - 2 * TAILB;
  localparam int JW    = $clog2(NFULL + 2);
  localparam logic [JW-1:0] JLAST = JW'(NFULL - 1);
  localparam hstate_e AFTER_BLK = (TAILB != 0) ? TAIL : FINAL;
  localparam hstate_e AFTER_ACC = (NFULL != 0) ? BLOCK : AFTER_BLK;
`ifdef HASHER_FMIX_EN
  localparam int LEN   = (KMER_SIZE + 3) / 4;
`endif

  hstate_e          state_q;
  logic [BUFW-1:0]  kbuf_q;
  logic [TAG_W-1:0] tag_q;
  h32_t             h_q;
  logic [JW-1:0]    j_q;

  logic             in_ready_q;
  logic             out_valid_q;
  h32_t             out_h1_q;
  logic [H2_W-1:0]  out_h2_q;
  logic [TAG_W-1:0] out_tag_q;

  h32_t blk_w;
  h32_t tail_w;
  h32_t round_w;
  h32_t h_rnd;
  h32_t h_fin;

  assign blk_w   = kbuf_q[BUFW-1 -: 32];
  assign tail_w  = blk_w >> TSH;
  assign round_w = (state_q == TAIL) ? tail_w : blk_w;

  murmur_round u_round (
    .h_in    (h_q),
    .w       (round_w),
    .is_tail (state_q == TAIL),
    .h_out   (h_rnd)
  );

  always_comb begin
`ifdef HASHER_FMIX_EN
    h_fin = fmix32(h_q ^ h32_t'(LEN));
`else
    h_fin = h_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kbuf_q      <= '0;
      tag_q       <= '0;
      h_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_h1_q    <= '0;
      out_h2_q    <= '0;
      out_tag_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            kbuf_q     <= {bus.in_kmer, {PADW{1'b0}}};
            tag_q      <= bus.in_tag;
            h_q        <= SEED;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= AFTER_ACC;
          end
        end
        BLOCK: begin
          h_q    <= h_rnd;
          kbuf_q <= kbuf_q << 32;
          j_q    <= j_q + JW'(1);
          if (j_q == JLAST) begin
            state_q <= AFTER_BLK;
          end
        end
        TAIL: begin
          h_q     <= h_rnd;
          state_q <= FINAL;
        end
        FINAL: begin
          out_h1_q    <= h_fin;
          out_h2_q    <= h_fin[H2_W-1:0];
          out_tag_q   <= tag_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Handshake returns to IDLE; the next accept can only happen a cycle later.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_h1    = out_h1_q;
  assign bus.out_h2    = out_h2_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_murmur_kmer_hasher_seq.sv
// Purpose:      self-checking bench for murmur_kmer_hasher_seq at K = 16, 32, 37, 48 and 7.
// Latency:      n/a.
// Backpressure: drives out_ready low/high to exercise result holding and back-to-back flow.
`timescale 1ns/1ps

module tb_murmur_kmer_hasher_seq;

  localparam int NK = 5;

  function automatic int kof(input int i);
    case (i)
      0:       return 16;
      1:       return 32;
      2:       return 37;
      3:       return 48;
      default: return 7;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a       [NK];
  logic        in_valid_a  [NK];
  logic        in_ready_a  [NK];
  logic [95:0] kmer_a      [NK];
  logic [7:0]  tag_a       [NK];
  logic        out_valid_a [NK];
  logic        out_ready_a [NK];
  logic [31:0] oh1_a       [NK];
  logic [7:0]  oh2_a       [NK];
  logic [7:0]  otag_a      [NK];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < NK; gi++) begin : g
    localparam int K = kof(gi);
    murmur_kmer_hasher_seq_if #(.KMER_SIZE(K), .TAG_W(8), .H2_W(8)) bus ();
    murmur_kmer_hasher_seq #(
      .KMER_SIZE(K), .NUM_OF_BUCKETS(256), .SEED(32'h8f83adef), .TAG_W(8)
    ) dut (
      .clk (clk),
      .rst (rst_a[gi]),
      .bus (bus.slave)
    );
    assign bus.in_valid    = in_valid_a[gi];
    assign bus.in_kmer     = kmer_a[gi][2*K-1:0];
    assign bus.in_tag      = tag_a[gi];
    assign bus.out_ready   = out_ready_a[gi];
    assign in_ready_a[gi]  = bus.in_ready;
    assign out_valid_a[gi] = bus.out_valid;
    assign oh1_a[gi]       = bus.out_h1;
    assign oh2_a[gi]       = bus.out_h2;
    assign otag_a[gi]      = bus.out_tag;
  end

  // Reference: straight loop over bases, word packing first-base-in-MSBs.
  function automatic logic [31:0] ref_h1(input int k, input logic [95:0] km);
    logic [31:0] h, w, kk;
    logic [95:0] t;
    int nfull, tailb, nb;
    nfull = k / 16;
    tailb = k % 16;
    h = 32'h8f83adef;
    for (int j = 0; j <= nfull; j++) begin
      nb = (j < nfull) ? 16 : tailb;
      if (nb != 0) begin
        w = '0;
        for (int i = 0; i < nb; i++) begin
          t = km >> (2 * k - 2 - 2 * (16 * j + i));
          w = {w[29:0], t[1:0]};
        end
        kk = w * 32'hcc9e2d51;
        kk = {kk[16:0], kk[31:17]};
        kk = kk * 32'h1b873593;
        h  = h ^ kk;
        if (j < nfull) begin
          h = {h[18:0], h[31:19]};
          h = h * 32'd5 + 32'he6546b64;
        end
      end
    end
`ifdef HASHER_FMIX_EN
    h = h ^ 32'((k + 3) / 4);
    h = h ^ (h >> 16);
    h = h * 32'h85ebca6b;
    h = h ^ (h >> 13);
    h = h * 32'hc2b2ae35;
    h = h ^ (h >> 16);
`endif
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    while (out_valid_a[idx] !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Offer one k-mer from IDLE, check latency/result/tag, then drain it.
  task automatic hash_one(input int idx, input logic [95:0] km, input logic [7:0] tg,
                          input logic [31:0] eh, input int elat, input string nm);
    int lat;
    kmer_a[idx]      = km;
    tag_a[idx]       = tg;
    in_valid_a[idx]  = 1'b1;
    out_ready_a[idx] = 1'b0;
    step();
    in_valid_a[idx] = 1'b0;
    kmer_a[idx]     = '1;
    tag_a[idx]      = 8'hee;
    chk({nm, " busy"}, in_ready_a[idx], 1'b0);
    wait_out(idx, lat);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " h1"}, oh1_a[idx], eh);
    chk({nm, " h2"}, oh2_a[idx], eh[7:0]);
    chk({nm, " tag"}, otag_a[idx], tg);
    out_ready_a[idx] = 1'b1;
    step();
    out_ready_a[idx] = 1'b0;
    chk({nm, " drained"}, out_valid_a[idx], 1'b0);
    chk({nm, " ready"}, in_ready_a[idx], 1'b1);
  endtask

  typedef struct {
    int          inst;
    logic [95:0] kmer;
    logic [7:0]  tag;
    logic [31:0] h1;
    int          lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t        vt [9];
    logic [95:0] bk [3];
    logic [7:0]  got_tag [3];
    logic [31:0] got_h1 [3];
    int          acc_cyc [3];
    logic [95:0] hk_a, hk_b, rk_a, rk_b;
    int          lat, got, sent, extra;
    logic        acc;

    vt[0] = '{0, 96'h0,                        8'h11, 32'h0, 2};
    vt[1] = '{0, 96'he41b9c27,                 8'h12, 32'h0, 2};
    vt[2] = '{1, 96'h3c9a51e2_8f07d6b4,        8'h21, 32'h0, 3};
    vt[3] = '{1, 96'hffffffff_ffffffff,        8'h22, 32'h0, 3};
    vt[4] = '{2, 96'h2c4f1_9e3c5a17_b4d2,      8'h31, 32'h0, 4};
    vt[5] = '{2, 96'h3ff_ffffffff_ffffffff,    8'h32, 32'h0, 4};
    vt[6] = '{3, 96'h01234567_89abcdef_fedcba98, 8'h41, 32'h0, 4};
    vt[7] = '{4, 96'h2d1b,                     8'h51, 32'h0, 2};
    vt[8] = '{4, 96'h0001,                     8'h52, 32'h0, 2};
    for (int i = 0; i < 9; i++) vt[i].h1 = ref_h1(kof(vt[i].inst), vt[i].kmer);
`ifndef HASHER_FMIX_EN
    // Legacy result for 16 zero bases, worked by hand from the seed.
    vt[0].h1 = 32'h330a2514;
`endif

    for (int i = 0; i < NK; i++) begin
      rst_a[i] = 1'b1; in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b0;
      kmer_a[i] = '0; tag_a[i] = '0;
    end
    step();
    for (int i = 0; i < NK; i++) begin
      chk($sformatf("rst%0d out_valid", i), out_valid_a[i], 1'b0);
      chk($sformatf("rst%0d in_ready", i), in_ready_a[i], 1'b1);
      chk($sformatf("rst%0d h1", i), oh1_a[i], 32'h0);
      chk($sformatf("rst%0d h2", i), oh2_a[i], 8'h0);
      chk($sformatf("rst%0d tag", i), otag_a[i], 8'h0);
    end
    step();
    for (int i = 0; i < NK; i++) rst_a[i] = 1'b0;
    step();

    for (int i = 0; i < 9; i++)
      hash_one(vt[i].inst, vt[i].kmer, vt[i].tag, vt[i].h1, vt[i].lat, $sformatf("v%0d", i));

    // Result held under backpressure while a new k-mer waits on the input.
    hk_a = 96'h1e2d3_c4b5a697_88796a5b;
    hk_b = 96'h0a5a5_5a5a5a5a_c3c3c3c3;
    kmer_a[2] = hk_a; tag_a[2] = 8'h5a; in_valid_a[2] = 1'b1; out_ready_a[2] = 1'b0;
    step();
    chk("hold busy", in_ready_a[2], 1'b0);
    kmer_a[2] = hk_b; tag_a[2] = 8'hab;
    wait_out(2, lat);
    chk("hold latency", lat, 4);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold c%0d h1", c), oh1_a[2], ref_h1(37, hk_a));
      chk($sformatf("hold c%0d tag", c), otag_a[2], 8'h5a);
      chk($sformatf("hold c%0d valid", c), out_valid_a[2], 1'b1);
      chk($sformatf("hold c%0d in_ready", c), in_ready_a[2], 1'b0);
      step();
    end
    out_ready_a[2] = 1'b1;
    step();
    out_ready_a[2] = 1'b0;
    chk("release single", out_valid_a[2], 1'b0);
    chk("release ready", in_ready_a[2], 1'b1);
    step();
    in_valid_a[2] = 1'b0;
    chk("queued accept", in_ready_a[2], 1'b0);
    wait_out(2, lat);
    chk("queued latency", lat, 4);
    chk("queued h1", oh1_a[2], ref_h1(37, hk_b));
    chk("queued tag", otag_a[2], 8'hab);
    out_ready_a[2] = 1'b1;
    step();
    out_ready_a[2] = 1'b0;
    chk("queued drained", out_valid_a[2], 1'b0);

    // Back-to-back stream of three k-mers with the consumer always ready.
    bk[0] = 96'h9b1c2d3e_4f506172;
    bk[1] = 96'h00000000_00000003;
    bk[2] = 96'hc0000000_00000000;
    out_ready_a[1] = 1'b1;
    sent = 0; got = 0;
    kmer_a[1] = bk[0]; tag_a[1] = 8'd1; in_valid_a[1] = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      acc = in_valid_a[1] && in_ready_a[1];
      if (out_valid_a[1] === 1'b1) begin
        got_tag[got] = otag_a[1];
        got_h1[got]  = oh1_a[1];
        got++;
      end
      step();
      if (acc) begin
        acc_cyc[sent] = cyc;
        sent++;
        if (sent < 3) begin
          kmer_a[1] = bk[sent];
          tag_a[1]  = 8'(sent + 1);
        end else begin
          in_valid_a[1] = 1'b0;
        end
      end
    end
    chk("b2b count", got, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b%0d tag", i), got_tag[i], 8'(i + 1));
      chk($sformatf("b2b%0d h1", i), got_h1[i], ref_h1(32, bk[i]));
    end
    chk("b2b spacing01", acc_cyc[1] - acc_cyc[0], 5);
    chk("b2b spacing12", acc_cyc[2] - acc_cyc[1], 5);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_a[1] === 1'b1) extra++;
      step();
    end
    chk("b2b no duplicate", extra, 0);
    out_ready_a[1] = 1'b0;

    // Reset while the K=48 engine is between blocks.
    rk_a = 96'h55555555_aaaaaaaa_12345678;
    rk_b = 96'h87654321_0fedcba9_13579bdf;
    kmer_a[3] = rk_a; tag_a[3] = 8'h77; in_valid_a[3] = 1'b1;
    step();
    in_valid_a[3] = 1'b0;
    step();
    rst_a[3] = 1'b1;
    step();
    chk("midrst out_valid", out_valid_a[3], 1'b0);
    chk("midrst in_ready", in_ready_a[3], 1'b1);
    chk("midrst h1", oh1_a[3], 32'h0);
    chk("midrst h2", oh2_a[3], 8'h0);
    chk("midrst tag", otag_a[3], 8'h0);
    rst_a[3] = 1'b0;
    out_ready_a[3] = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_a[3] === 1'b1) extra++;
      step();
    end
    chk("midrst dropped", extra, 0);
    out_ready_a[3] = 1'b0;
    hash_one(3, rk_b, 8'h78, ref_h1(48, rk_b), 4, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
